// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the program memory loader: FSM encodings, length field width
// and byte-lane sizing helpers.
package program_memory_loader_pkg;

  localparam int LEN_WIDTH = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // A single-byte word still needs a one-bit lane counter to stay legal.
  function automatic int lane_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// Host byte stream plus program memory write port used by the loader.
// master = host/memory side, slave = loader.
interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_write_en;
  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, mem_write_en, mem_address, mem_write_data
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, mem_write_en, mem_address, mem_write_data
  );
endinterface

// File: rtl/program_memory_loader_word_assembler.sv
// Packs accepted bytes little-endian into a word: each new byte enters at the top and
// shifts right, so after a full word the first byte sits in bits [7:0].
module program_memory_loader_word_assembler
  import program_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_complete
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int LW  = lane_width(BPW);

  logic [LW-1:0] lane;

  assign word_complete = byte_en && (lane == LW'(BPW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (byte_en) begin
      lane <= word_complete ? '0 : lane + 1'b1;
      word <= DATA_WIDTH'({byte_data, word} >> 8);
    end
  end
endmodule

// File: rtl/program_memory_loader.sv
// Program memory loader: receives LEN_LO, LEN_HI, then word data; writes words from address 0
// and holds the core in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR byte check.
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  program_memory_loader_if.slave bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   cpu_hold
);
  // state | meaning
  // IDLE  | waiting for start after reset, core held
  // LEN0  | expecting low byte of word count
  // LEN1  | expecting high byte of word count, range check
  // DATA  | accepting data bytes of current word
  // WRITE | one-cycle write strobe of assembled word
  // CHECK | expecting XOR checksum byte (checksum build only)
  // DONE  | load finished, core released
  // ERROR | load aborted, core held

  logic [2:0]            state, state_nxt;
  logic [7:0]            len_lo;
  logic [LEN_WIDTH-1:0]  word_total, len_rx, word_cnt_inc;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic                  accept, start_ok, last_word, asm_byte_en, asm_complete;
  logic [DATA_WIDTH-1:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            checksum;
`endif

  assign accept       = bus.byte_valid && bus.byte_ready;
  assign start_ok     = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign len_rx       = {bus.byte_data, len_lo};
  assign word_cnt_inc = LEN_WIDTH'(word_cnt) + 1'b1;
  assign last_word    = (word_cnt_inc == word_total);
  assign asm_byte_en  = accept && (state == ST_DATA);

  program_memory_loader_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_ok),
    .byte_en       (asm_byte_en),
    .byte_data     (bus.byte_data),
    .word          (asm_word),
    .word_complete (asm_complete)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_LEN0;
      ST_LEN0: if (accept) state_nxt = ST_LEN1;
      ST_LEN1: begin
        if (accept) begin
          if (len_rx == '0)                               state_nxt = ST_DONE;
          else if (len_rx > LEN_WIDTH'(MEMORY_DEPTH))     state_nxt = ST_ERROR;
          else                                            state_nxt = ST_DATA;
        end
      end
      ST_DATA: if (asm_complete) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: if (accept) state_nxt = (bus.byte_data == checksum) ? ST_DONE : ST_ERROR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len_lo     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok)                       word_cnt   <= '0;
      else if (state == ST_WRITE)         word_cnt   <= word_cnt + 1'b1;
      if (accept && state == ST_LEN0)     len_lo     <= bus.byte_data;
      if (accept && state == ST_LEN1)     word_total <= len_rx;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           checksum <= '0;
    else if (start_ok)    checksum <= '0;
    else if (asm_byte_en) checksum <= checksum ^ bus.byte_data;
  end
`endif

  assign bus.byte_ready     = (state == ST_LEN0) || (state == ST_LEN1) ||
                              (state == ST_DATA) || (state == ST_CHECK);
  assign bus.mem_write_en   = (state == ST_WRITE);
  assign bus.mem_address    = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, word_cnt};
  assign bus.mem_write_data = asm_word;

  assign busy     = bus.byte_ready || (state == ST_WRITE);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign cpu_hold = (state != ST_DONE);
endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: table of load vectors plus hand sequences
// for reset mid-load, start while busy and (with LOADER_CHECKSUM_EN) a bad checksum.
module tb_program_memory_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, cpu_hold;

  program_memory_loader_if #(.DATA_WIDTH(32)) bus ();

  program_memory_loader #(
    .MEMORY_DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write log captured mid-cycle while the strobe is stable.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  always @(negedge clk) begin
    if (bus.mem_write_en === 1'b1) begin
      wr_addr.push_back(bus.mem_address);
      wr_data.push_back(bus.mem_write_data);
    end
  end

  typedef struct {
    string       name;
    logic [15:0] len;
    logic [63:0] data;
    bit          gen;
    bit          exp_done;
    bit          exp_error;
    int          exp_writes;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout byte=%h ready=%b", b, bus.byte_ready);
    end else begin
      @(posedge clk);
    end
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      failures++;
      $display("FAIL end_timeout done=%b error=%b", done, error);
    end
  endtask

  function automatic logic [7:0] vec_byte(input vec_t v, input int k);
    logic [63:0] d;
    d = v.data;
    return v.gen ? 8'(k) : d[8*(k%8) +: 8];
  endfunction

  task automatic run_vec(input vec_t v);
    int base, nbytes;
    logic [7:0] b, x;
    base = wr_addr.size();
    nbytes = v.exp_error ? 0 : int'(v.len) * 4;
    x = 8'h00;
    pulse_start();
    chk({v.name, ":busy_after_start"}, 32'(busy), 32'd1);
    chk({v.name, ":done_cleared"}, 32'(done), 32'd0);
    send_byte(v.len[7:0], 0);
    send_byte(v.len[15:8], 0);
    for (int k = 0; k < nbytes; k++) begin
      b = vec_byte(v, k);
      x = x ^ b;
      send_byte(b, 0);
    end
`ifdef LOADER_CHECKSUM_EN
    if (nbytes > 0) send_byte(x, 0);
`endif
    wait_end();
    chk({v.name, ":done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, ":error"}, 32'(error), 32'(v.exp_error));
    chk({v.name, ":cpu_hold"}, 32'(cpu_hold), 32'(!v.exp_done));
    chk({v.name, ":busy_end"}, 32'(busy), 32'd0);
    chk({v.name, ":writes"}, 32'(wr_addr.size() - base), 32'(v.exp_writes));
    if (v.exp_writes > 0 && wr_addr.size() > base) begin
      chk({v.name, ":first_addr"}, wr_addr[base], 32'd0);
      chk({v.name, ":first_word"}, wr_data[base], v.exp_first);
      chk({v.name, ":last_addr"}, wr_addr[wr_addr.size()-1], v.exp_last_addr);
      chk({v.name, ":last_word"}, wr_data[wr_data.size()-1], v.exp_last);
    end
    if (v.exp_error) begin
      bus.byte_data  = 8'h55;
      bus.byte_valid = 1'b1;
      @(negedge clk);
      chk({v.name, ":ready_in_error"}, 32'(bus.byte_ready), 32'd0);
      @(negedge clk);
      chk({v.name, ":no_write_in_error"}, 32'(wr_addr.size() - base), 32'd0);
      bus.byte_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;

    vecs[0] = '{"two_words",  16'd2,      64'h000000B3_00000013, 1'b0, 1'b1, 1'b0, 2,  32'h00000013, 32'h000000B3, 32'd1};
    vecs[1] = '{"zero_len",   16'd0,      64'h0,                 1'b0, 1'b1, 1'b0, 0,  32'h0,        32'h0,        32'd0};
    vecs[2] = '{"over_depth", 16'd65,     64'h0,                 1'b0, 1'b0, 1'b1, 0,  32'h0,        32'h0,        32'd0};
    vecs[3] = '{"one_word",   16'd1,      64'h00000000_12345678, 1'b0, 1'b1, 1'b0, 1,  32'h12345678, 32'h12345678, 32'd0};
    vecs[4] = '{"full_depth", 16'd64,     64'h0,                 1'b1, 1'b1, 1'b0, 64, 32'h03020100, 32'hFFFEFDFC, 32'd63};
    vecs[5] = '{"len_ffff",   16'hFFFF,   64'h0,                 1'b0, 1'b0, 1'b1, 0,  32'h0,        32'h0,        32'd0};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst:byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst:mem_write_en", 32'(bus.mem_write_en), 32'd0);
    chk("rst:mem_address", bus.mem_address, 32'd0);
    chk("rst:mem_write_data", bus.mem_write_data, 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:error", 32'(error), 32'd0);
    chk("rst:cpu_hold", 32'(cpu_hold), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start pulse during DATA must not restart the load.
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_start();
    chk("busy_start:busy_mid", 32'(busy), 32'd1);
    chk("busy_start:hold_mid", 32'(cpu_hold), 32'd1);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
`endif
    wait_end();
    chk("busy_start:done", 32'(done), 32'd1);
    chk("busy_start:writes", 32'(wr_addr.size() - base), 32'd1);
    if (wr_data.size() > base) chk("busy_start:word", wr_data[base], 32'hDDCCBBAA);

    // Reset after the third data byte, with gaps on byte_valid.
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h02, $urandom_range(0, 2));
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h11, $urandom_range(0, 2));
    send_byte(8'h22, $urandom_range(0, 2));
    send_byte(8'h33, $urandom_range(0, 2));
    reset = 1'b0;
    @(negedge clk);
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:cpu_hold", 32'(cpu_hold), 32'd1);
    chk("midrst:byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst:mem_write_en", 32'(bus.mem_write_en), 32'd0);
    bus.byte_data  = 8'h44;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst:idle_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst:idle_busy", 32'(busy), 32'd0);
    chk("midrst:no_write", 32'(wr_addr.size() - base), 32'd0);
    bus.byte_valid = 1'b0;
    run_vec(vecs[3]);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum: words stay written, load ends in error.
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    send_byte(8'h40, 0);
    send_byte(8'h10 ^ 8'h20 ^ 8'h30 ^ 8'h40 ^ 8'hFF, 0);
    wait_end();
    chk("badsum:error", 32'(error), 32'd1);
    chk("badsum:done", 32'(done), 32'd0);
    chk("badsum:cpu_hold", 32'(cpu_hold), 32'd1);
    chk("badsum:writes", 32'(wr_addr.size() - base), 32'd1);
    if (wr_data.size() > base) chk("badsum:word", wr_data[base], 32'h40302010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
